// File: rtl/tag_cam_matrix.sv
// Small registered tag CAM: allocate/free ports plus parallel lookup ports
// returning per-entry hit vectors; optional one-cycle output register.
module tag_cam_matrix #(
   parameter int unsigned width_p      = 8,
   parameter int unsigned els_p        = 8,
   parameter int unsigned num_lookup_p = 2,
   parameter int unsigned pipe_p       = 1,
   localparam int unsigned id_w        = $clog2(els_p),
   localparam int unsigned cnt_w       = $clog2(els_p + 1)
) (
   input  logic                                        clk_i,
   input  logic                                        reset_n_i,
   input  logic                                        alloc_v_i,
   input  logic [width_p-1:0]                          alloc_tag_i,
   output logic                                        alloc_ready_o,
   output logic [id_w-1:0]                             alloc_id_o,
   input  logic                                        free_v_i,
   input  logic [id_w-1:0]                             free_id_i,
   input  logic [num_lookup_p-1:0]                     lookup_v_i,
   input  logic [num_lookup_p-1:0][width_p-1:0]        lookup_tag_i,
   output logic [num_lookup_p-1:0]                     hit_v_o,
   output logic [num_lookup_p-1:0][els_p-1:0]          hit_o,
   output logic [num_lookup_p-1:0]                     any_hit_o,
   output logic [cnt_w-1:0]                            count_o,
   output logic                                        empty_o
);

   logic [els_p-1:0]   valid_q;
   logic [els_p-1:0]   valid_d;
   logic [width_p-1:0] tag_q [els_p];
   logic [cnt_w-1:0]   count_d;
   logic [id_w-1:0]    alloc_id_d;
   logic               alloc_fire_c;
   logic               free_fire_c;

   // A free only counts when it hits an in-range, currently valid slot
   assign alloc_fire_c = alloc_v_i & alloc_ready_o;
   assign free_fire_c  = free_v_i && (32'(free_id_i) < els_p) && valid_q[free_id_i];

   // Next valid bits, next count and next lowest-free slot
   always_comb begin
      valid_d    = valid_q;
      count_d    = count_o;
      alloc_id_d = '0;
      if (free_fire_c) begin
         valid_d[free_id_i] = 1'b0;
      end
      if (alloc_fire_c) begin
         valid_d[alloc_id_o] = 1'b1;
      end
      count_d = count_o + cnt_w'(alloc_fire_c) - cnt_w'(free_fire_c);
      for (int e = int'(els_p) - 1; e >= 0; e--) begin
         if (!valid_d[e]) begin
            alloc_id_d = id_w'(e);
         end
      end
   end

   // Allocation status is registered from the next-state valid vector
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         valid_q       <= '0;
         count_o       <= '0;
         empty_o       <= 1'b1;
         alloc_ready_o <= 1'b1;
         alloc_id_o    <= '0;
      end else begin
         valid_q       <= valid_d;
         count_o       <= count_d;
         empty_o       <= (count_d == '0);
         alloc_ready_o <= ~(&valid_d);
         alloc_id_o    <= alloc_id_d;
      end
   end

   // Tag storage carries no reset; contents are qualified by valid_q
   always_ff @(posedge clk_i) begin
      if (alloc_fire_c) begin
         tag_q[alloc_id_o] <= alloc_tag_i;
      end
   end

   logic [num_lookup_p-1:0][els_p-1:0] hit_c;
   logic [num_lookup_p-1:0]            any_c;

   // Lookups see pre-update state; an idle port yields all zeros
   always_comb begin
      hit_c = '0;
      any_c = '0;
      for (int p = 0; p < int'(num_lookup_p); p++) begin
         for (int e = 0; e < int'(els_p); e++) begin
            hit_c[p][e] = lookup_v_i[p] && valid_q[e] && (tag_q[e] == lookup_tag_i[p]);
         end
         any_c[p] = |hit_c[p];
      end
   end

   if (pipe_p != 0) begin : g_pipe
      always_ff @(posedge clk_i or negedge reset_n_i) begin
         if (!reset_n_i) begin
            hit_v_o   <= '0;
            hit_o     <= '0;
            any_hit_o <= '0;
         end else begin
            hit_v_o   <= lookup_v_i;
            hit_o     <= hit_c;
            any_hit_o <= any_c;
         end
      end
   end else begin : g_comb
      assign hit_v_o   = lookup_v_i;
      assign hit_o     = hit_c;
      assign any_hit_o = any_c;
   end

endmodule

// File: tb/tb_tag_cam_matrix.sv
// Scoreboard bench for tag_cam_matrix (default parameters, pipelined results).
module tb_tag_cam_matrix;
   localparam int unsigned W = 8;
   localparam int unsigned E = 8;
   localparam int unsigned L = 2;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             alloc_v = 1'b0;
   logic [W-1:0]     alloc_tag = '0;
   logic             alloc_ready;
   logic [2:0]       alloc_id;
   logic             free_v = 1'b0;
   logic [2:0]       free_id = '0;
   logic [L-1:0]     lookup_v = '0;
   logic [L-1:0][W-1:0] lookup_tag = '0;
   logic [L-1:0]     hit_v;
   logic [L-1:0][E-1:0] hit;
   logic [L-1:0]     any_hit;
   logic [3:0]       count;
   logic             empty;

   tag_cam_matrix #(.width_p(W), .els_p(E), .num_lookup_p(L), .pipe_p(1)) dut (
      .clk_i(clk), .reset_n_i(reset_n),
      .alloc_v_i(alloc_v), .alloc_tag_i(alloc_tag),
      .alloc_ready_o(alloc_ready), .alloc_id_o(alloc_id),
      .free_v_i(free_v), .free_id_i(free_id),
      .lookup_v_i(lookup_v), .lookup_tag_i(lookup_tag),
      .hit_v_o(hit_v), .hit_o(hit), .any_hit_o(any_hit),
      .count_o(count), .empty_o(empty));

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      logic [E-1:0] hv;
      logic         any;
      int           at;
   } exp_t;
   exp_t q0[$];
   exp_t q1[$];

   // Reference model: which slots hold a live tag
   bit         mvalid [E];
   logic [W-1:0] mtag [E];

   function automatic int mcount();
      int n = 0;
      for (int i = 0; i < int'(E); i++) if (mvalid[i]) n++;
      return n;
   endfunction

   function automatic int mfirst();
      for (int i = 0; i < int'(E); i++) if (!mvalid[i]) return i;
      return 0;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus; entered and left at posedge+1
   task automatic step(input logic av, input logic [W-1:0] at, input logic fv,
                       input logic [2:0] fid, input logic [L-1:0] lv,
                       input logic [W-1:0] lt0, input logic [W-1:0] lt1);
      exp_t e;
      logic [W-1:0] lt [L];
      bit acc, fe;
      int aid;
      lt[0] = lt0; lt[1] = lt1;
      alloc_v = av; alloc_tag = at; free_v = fv; free_id = fid;
      lookup_v = lv; lookup_tag[0] = lt0; lookup_tag[1] = lt1;
      check("alloc_ready", 32'(alloc_ready), 32'(mcount() < int'(E)));
      if (mcount() < int'(E)) check("alloc_id", 32'(alloc_id), 32'(mfirst()));
      check("count", 32'(count), 32'(mcount()));
      check("empty", 32'(empty), 32'(mcount() == 0));
      for (int p = 0; p < int'(L); p++) begin
         if (lv[p]) begin
            e.hv = '0;
            for (int i = 0; i < int'(E); i++) e.hv[i] = mvalid[i] && (mtag[i] == lt[p]);
            e.any = (e.hv != '0);
            e.at  = cyc + 1;
            if (p == 0) q0.push_back(e); else q1.push_back(e);
         end
      end
      acc = av && (mcount() < int'(E));
      aid = mfirst();
      fe  = fv && mvalid[fid];
      @(posedge clk); #1;
      if (fe) mvalid[fid] = 1'b0;
      if (acc) begin mvalid[aid] = 1'b1; mtag[aid] = at; end
      alloc_v = 1'b0; free_v = 1'b0; lookup_v = '0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      check("rst_count", 32'(count), 0);
      check("rst_empty", 32'(empty), 1);
      check("rst_ready", 32'(alloc_ready), 1);
      check("rst_id", 32'(alloc_id), 0);
      check("rst_hit_v", 32'(hit_v), 0);
      check("rst_hit", 32'(hit), 0);
      q0.delete(); q1.delete();
      for (int i = 0; i < int'(E); i++) mvalid[i] = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   // Monitor: pops an expectation whenever a port presents a result
   always @(negedge clk) begin
      for (int p = 0; p < int'(L); p++) begin
         if (hit_v[p]) begin
            exp_t e;
            bit got = 1'b0;
            if (p == 0 && q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
            if (p == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
            checks++;
            if (!got) begin
               errors++;
               $display("FAIL unexpected_result port%0d: got hit_v=1 expected none", p);
            end else begin
               check($sformatf("latency p%0d", p), 32'(cyc), 32'(e.at));
               check($sformatf("hit p%0d", p), 32'(hit[p]), 32'(e.hv));
               check($sformatf("any_hit p%0d", p), 32'(any_hit[p]), 32'(e.any));
            end
         end else begin
            check($sformatf("idle_hit p%0d", p), {31'(hit[p]), any_hit[p]}, 0);
         end
      end
   end

   initial begin
      for (int i = 0; i < int'(E); i++) begin mvalid[i] = 1'b0; mtag[i] = '0; end
      #12;
      do_reset();

      // Fill the table, then an allocation while full
      for (int i = 0; i < 8; i++) step(1'b1, 8'h10 + 8'(i), 1'b0, 3'd0, 2'b00, 8'h0, 8'h0);
      check("full_count", 32'(count), 8);
      check("full_ready", 32'(alloc_ready), 0);
      step(1'b1, 8'h55, 1'b0, 3'd0, 2'b00, 8'h0, 8'h0);
      step(1'b0, 8'h00, 1'b0, 3'd0, 2'b11, 8'h55, 8'h10);
      check("full_miss_55", 32'(any_hit[0]), 0);
      check("hit_10", 32'(hit[1]), 32'h01);

      // Free while full: same-cycle alloc is dropped, slot reused next cycle
      step(1'b1, 8'h99, 1'b1, 3'd3, 2'b00, 8'h0, 8'h0);
      check("free_count", 32'(count), 7);
      check("reuse_id", 32'(alloc_id), 3);
      step(1'b1, 8'hAA, 1'b0, 3'd0, 2'b00, 8'h0, 8'h0);
      step(1'b0, 8'h00, 1'b0, 3'd0, 2'b01, 8'hAA, 8'h0);
      check("hit_AA", 32'(hit[0]), 32'h08);

      // Duplicate tags hit together; ports are independent
      do_reset();
      step(1'b1, 8'h21, 1'b0, 3'd0, 2'b00, 8'h0, 8'h0);
      step(1'b1, 8'h30, 1'b0, 3'd0, 2'b00, 8'h0, 8'h0);
      step(1'b1, 8'h21, 1'b0, 3'd0, 2'b00, 8'h0, 8'h0);
      step(1'b0, 8'h00, 1'b0, 3'd0, 2'b11, 8'h21, 8'h22);
      check("dup_hit", 32'(hit[0]), 32'h05);
      check("dup_any", 32'(any_hit), 32'b01);

      // Lookup never sees a same-cycle alloc
      step(1'b1, 8'h33, 1'b0, 3'd0, 2'b01, 8'h33, 8'h0);
      check("bypass_miss", 32'(any_hit[0]), 0);
      step(1'b0, 8'h00, 1'b0, 3'd0, 2'b01, 8'h33, 8'h0);
      check("late_hit", 32'(hit[0]), 32'h08);

      // Free of an invalid slot, then reset with a result in flight
      step(1'b0, 8'h00, 1'b1, 3'd5, 2'b00, 8'h0, 8'h0);
      check("noop_free", 32'(count), 4);
      step(1'b0, 8'h00, 1'b0, 3'd0, 2'b11, 8'h21, 8'h33);
      check("inflight", 32'(hit_v), 32'b11);
      do_reset();

      // Randomized traffic over a small tag space to force collisions
      for (int n = 0; n < 400; n++) begin
         step(1'($urandom_range(0, 2) != 0), 8'h40 + 8'($urandom_range(0, 5)),
              1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              2'($urandom_range(0, 3)),
              8'h40 + 8'($urandom_range(0, 6)), 8'h40 + 8'($urandom_range(0, 6)));
      end
      step(1'b0, 8'h00, 1'b0, 3'd0, 2'b00, 8'h0, 8'h0);
      step(1'b0, 8'h00, 1'b0, 3'd0, 2'b00, 8'h0, 8'h0);
      check("drained", 32'(q0.size() + q1.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
